id_exe_hazard_ctrl: RTL
=======================

Name: id_exe_hazard_ctrl

Overview:
- Pipeline control block that consumes the ID/EXE register contents (Dest, MEM_R_EN, WB_EN) and the EXE branch outcome.
- Generates freeze, flush and bubble controls back toward IF, ID and the ID/EXE register.
- Sits beside the ID/EXE register. Covers load-use stalls, taken-branch flushes and multi-cycle data-memory waits, using a small FSM and a flush counter.

Parameters:
- FORWARD_EN, 1, 1: stall only on load-use (EXE-stage load). 0: stall on any RAW against the EXE or MEM stage.
- FLUSH_CYCLES, 1, number of consecutive cycles the flush is asserted after a taken branch (1..7).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- src1  in  5  ID-stage source register 1
- src2  in  5  ID-stage source register 2
- two_src  in  1  ID instruction reads src2 (R-type or store)
- exe_dest  in  5  Dest held in the ID/EXE register
- exe_mem_r_en  in  1  MEM_R_EN held in the ID/EXE register
- exe_wb_en  in  1  WB_EN held in the ID/EXE register
- mem_dest  in  5  Dest held in the EXE/MEM register
- mem_wb_en  in  1  WB_EN held in the EXE/MEM register
- br_taken  in  1  branch resolved taken in EXE
- mem_busy  in  1  data memory not ready this cycle
- pc_freeze  out  1  hold PC
- ifid_freeze  out  1  hold the IF/ID register
- ifid_flush  out  1  load NOP into IF/ID
- idexe_bubble  out  1  load zero control (WB_EN, MEM_R_EN, MEM_W_EN, Br_taken = 0) into ID/EXE
- exemem_freeze  out  1  hold the ID/EXE and EXE/MEM registers
- state_o  out  2  FSM state: 0 = RUN, 1 = FLUSH, 2 = MEM_WAIT

Behaviour:
- Reset: state = RUN, flush counter = 0. While rst is high, all outputs are 0, including state_o = 0. Assertion mid-FLUSH or mid-MEM_WAIT abandons the sequence immediately.
- Hazard terms (combinational, same cycle):
  - hit_exe = exe_wb_en & exe_dest != 0 & (src1 == exe_dest | (two_src & src2 == exe_dest))
  - hit_mem = mem_wb_en & mem_dest != 0 & (src1 == mem_dest | (two_src & src2 == mem_dest))
  - FORWARD_EN = 1: raw = hit_exe & exe_mem_r_en
  - FORWARD_EN = 0: raw = hit_exe | hit_mem
- Priority, highest first: mem_busy > branch flush (br_taken, or state FLUSH) > raw.
- mem_busy = 1 in any state:
  - pc_freeze = ifid_freeze = exemem_freeze = 1; ifid_flush = idexe_bubble = 0.
  - Next state is MEM_WAIT; flush counter held.
  - A br_taken arriving while busy is ignored; EXE is frozen and re-presents it after the wait.
- MEM_WAIT with mem_busy = 0: outputs evaluated as in RUN this cycle; next state is RUN, or FLUSH if the counter is nonzero.
- RUN with br_taken = 1:
  - ifid_flush = idexe_bubble = 1 this cycle; pc_freeze = 0 so the target loads.
  - FLUSH_CYCLES = 1: stay in RUN.
  - FLUSH_CYCLES > 1: load counter with FLUSH_CYCLES-1 and go to FLUSH.
- FLUSH:
  - ifid_flush = idexe_bubble = 1.
  - Counter decrements each non-busy cycle; return to RUN when it reaches 0.
  - raw is ignored while flushing.
- raw = 1 with no busy and no flush: pc_freeze = ifid_freeze = idexe_bubble = 1, ifid_flush = 0. Held until raw clears, which takes 1 cycle for a load-use with FORWARD_EN = 1.
- No hazard: all control outputs 0.
- Register 0 never creates a hazard.
- Latency: all control outputs are combinational from inputs and state. Only state and counter are registered.

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined: adds output ports stall_count[31:0] and flush_count[31:0].
  - stall_count increments each cycle raw-stall or mem_busy freeze is active.
  - flush_count increments each cycle ifid_flush = 1.
  - Both saturate at 32'hFFFFFFFF and reset asynchronously to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load-use: exe_dest = 5, exe_mem_r_en = 1, exe_wb_en = 1, src1 = 5, FORWARD_EN = 1 -> pc_freeze = ifid_freeze = idexe_bubble = 1 for exactly 1 cycle; next cycle (exe_mem_r_en = 0 after the bubble) all 0.
- Zero register: exe_dest = 0, load in EXE, src1 = 0 -> no stall.
- Second source: same load, src2 = 5, two_src = 0 -> no stall; two_src = 1 -> stall.
- Branch with FLUSH_CYCLES = 3: br_taken pulse 1 cycle -> ifid_flush = idexe_bubble = 1 for 3 cycles, state_o sequence 0, 1, 1, 0; a concurrent load-use hazard produces no pc_freeze.
- Memory wait: mem_busy high for 4 cycles with br_taken = 1 -> freezes = 1 and ifid_flush = 0 for 4 cycles, state_o = 2; after release, 1-cycle flush with FLUSH_CYCLES = 1.
- Reset mid-FLUSH (FLUSH_CYCLES = 4, rst asserted asynchronously at cycle 2) -> outputs 0 immediately, state_o = 0 after release. With HAZARD_STATS_EN, flush_count = 0 after reset and equals 4 after an uninterrupted 4-cycle flush.

Source files
------------

// File: rtl/id_exe_hazard_ctrl_if.sv
// Hazard-control bundle between the ID/EXE pipeline registers and id_exe_hazard_ctrl.
// master = pipeline side (drives register contents), slave = hazard controller.
interface id_exe_hazard_ctrl_if;
   logic [4:0] src1;
   logic [4:0] src2;
   logic       two_src;
   logic [4:0] exe_dest;
   logic       exe_mem_r_en;
   logic       exe_wb_en;
   logic [4:0] mem_dest;
   logic       mem_wb_en;
   logic       br_taken;
   logic       mem_busy;
   logic       pc_freeze;
   logic       ifid_freeze;
   logic       ifid_flush;
   logic       idexe_bubble;
   logic       exemem_freeze;
   logic [1:0] state_o;

   modport master (
      output src1, src2, two_src, exe_dest, exe_mem_r_en, exe_wb_en,
             mem_dest, mem_wb_en, br_taken, mem_busy,
      input  pc_freeze, ifid_freeze, ifid_flush, idexe_bubble, exemem_freeze, state_o
   );

   modport slave (
      input  src1, src2, two_src, exe_dest, exe_mem_r_en, exe_wb_en,
             mem_dest, mem_wb_en, br_taken, mem_busy,
      output pc_freeze, ifid_freeze, ifid_flush, idexe_bubble, exemem_freeze, state_o
   );
endinterface

// File: rtl/id_exe_hazard_ctrl.sv
// Freeze/flush/bubble generation for load-use stalls, taken-branch flushes and data-memory waits.
// Optional HAZARD_STATS_EN adds saturating stall_count / flush_count outputs.
module id_exe_hazard_ctrl #(
   parameter int FORWARD_EN   = 1,
   parameter int FLUSH_CYCLES = 1
) (
   input  logic                clk,
   input  logic                rst,
   id_exe_hazard_ctrl_if.slave hz
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]         stall_count,
   output logic [31:0]         flush_count
`endif
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      FLUSH    = 2'd1,
      MEM_WAIT = 2'd2
   } state_e;

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

   state_e     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;

   logic hit_exe, hit_mem, raw;
   logic pc_frz_c, ifid_frz_c, ifid_flush_c, bubble_c, exemem_frz_c;

   assign hit_exe = hz.exe_wb_en && (hz.exe_dest != 5'd0) &&
                    ((hz.src1 == hz.exe_dest) || (hz.two_src && (hz.src2 == hz.exe_dest)));
   assign hit_mem = hz.mem_wb_en && (hz.mem_dest != 5'd0) &&
                    ((hz.src1 == hz.mem_dest) || (hz.two_src && (hz.src2 == hz.mem_dest)));
   assign raw     = (FORWARD_EN != 0) ? (hit_exe && hz.exe_mem_r_en) : (hit_exe || hit_mem);

   always_comb begin
      pc_frz_c     = 1'b0;
      ifid_frz_c   = 1'b0;
      ifid_flush_c = 1'b0;
      bubble_c     = 1'b0;
      exemem_frz_c = 1'b0;
      state_d      = state_q;
      cnt_d        = cnt_q;

      if (hz.mem_busy) begin
         // Whole pipe holds; a branch in EXE stays put and is re-seen after the wait.
         pc_frz_c     = 1'b1;
         ifid_frz_c   = 1'b1;
         exemem_frz_c = 1'b1;
         state_d      = MEM_WAIT;
      end else if (state_q == FLUSH) begin
         ifid_flush_c = 1'b1;
         bubble_c     = 1'b1;
         cnt_d        = (cnt_q != 3'd0) ? cnt_q - 3'd1 : 3'd0;
         state_d      = (cnt_q <= 3'd1) ? RUN : FLUSH;
      end else if (hz.br_taken) begin
         ifid_flush_c = 1'b1;
         bubble_c     = 1'b1;
         if (FLUSH_CYCLES > 1) begin
            cnt_d   = FLUSH_LOAD;
            state_d = FLUSH;
         end else begin
            state_d = RUN;
         end
      end else begin
         if (raw) begin
            pc_frz_c   = 1'b1;
            ifid_frz_c = 1'b1;
            bubble_c   = 1'b1;
         end
         // A wait that interrupted a flush resumes the remaining flush cycles.
         state_d = ((state_q == MEM_WAIT) && (cnt_q != 3'd0)) ? FLUSH : RUN;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs are forced low while reset is held, independent of the inputs.
   assign hz.pc_freeze     = !rst && pc_frz_c;
   assign hz.ifid_freeze   = !rst && ifid_frz_c;
   assign hz.ifid_flush    = !rst && ifid_flush_c;
   assign hz.idexe_bubble  = !rst && bubble_c;
   assign hz.exemem_freeze = !rst && exemem_frz_c;
   assign hz.state_o       = state_q;

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         if (pc_frz_c && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
         if (ifid_flush_c && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;
`endif

endmodule
